esm_issue_scheduler: RTL and testbench
======================================

// Module: esm_issue_scheduler
// PURPOSE
//  Out-of-order issue scheduler in front of the ESM instruction stream. Buffers up to bs decoded
//  instructions, tracks pending register writes with a scoreboard, and each cycle issues the oldest
//  hazard-free entry to the execute stage. Sits between fetch/decode and the ALU pipeline.
// PARAMETERS
//  Instr_word_size  32  instruction width; RV32 field layout (rd[11:7], rs1[19:15], rs2[24:20])
//  regnum           32  architectural registers; x0 is never busy
//  bs               16  buffer entries (>=2); bs_bits = $clog2(bs)
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 asynchronous, active-low reset
//  in_valid   in   1                 instruction offered
//  in_ready   out  1                 = !full (combinational)
//  Instr_in   in   Instr_word_size   instruction word
//  ALUSrc     in   1                 1: rs2 is an immediate, rs2 not checked
//  RegWrite   in   1                 1: instruction writes rd
//  out_valid  out  1                 issue register holds an instruction
//  out_ready  in   1                 execute stage accepts
//  Instr_out  out  Instr_word_size   issued instruction
//  out_slot   out  bs_bits           buffer slot the instruction came from
//  wb_valid   in   1                 writeback completes
//  wb_rd      in   5                 register being written back
// BEHAVIOUR
//  Reset (rst=0, async): all entry valid bits, age matrix and scoreboard cleared;
//   out_valid=0, Instr_out=0, out_slot=0. in_ready=1 after reset is released.
//  Enqueue: in_valid&in_ready at an edge writes the lowest-index free slot and marks it younger than
//   every valid entry. The new entry is not eligible for issue in its enqueue cycle.
//  Eligibility of valid entry e (all must hold):
//   - scoreboard clear for rs1, and for rs2 when ALUSrc=0 (RAW on in-flight writes)
//   - scoreboard clear for rd when RegWrite=1 (WAW on in-flight writes)
//   - no older valid entry writes e.rs1/e.rs2 (RAW), writes e.rd (WAW) or reads e.rd (WAR)
//   - register 0 never creates a hazard
//  Issue: the issue register loads when it is empty or out_ready=1. The oldest eligible entry is
//   selected, its slot is freed at the same edge, and the scoreboard bit for rd is set
//   when RegWrite=1 and rd!=0. Latency: enqueue at edge N -> earliest out_valid after edge N+1.
//  Backpressure: out_valid=1 & out_ready=0 -> Instr_out/out_slot held stable, nothing issues.
//  No eligible entry and out_ready=1 -> out_valid drops to 0 at the next edge.
//  Writeback: wb_valid clears scoreboard[wb_rd]. If the same edge also issues a writer of the same
//   register, the set wins. wb_rd=0 is ignored.
//  Full: all bs slots valid -> in_ready=0. Enqueue and issue on the same edge are legal; the slot
//   freed at that edge is usable from the next cycle.
// CONFIGURATION
//  ESM_SCHED_STATS_EN defined: adds outputs stat_issued[31:0] (count of issue-register loads) and
//   stat_stalls[31:0] (cycles with >=1 valid entry, free issue register and nothing eligible).
//   Both counters wrap and are cleared by rst.
//  ESM_SCHED_STATS_EN undefined: the stat ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package esm_pkg: RD_LSB=7, RS1_LSB=15, RS2_LSB=20, REG_IDX_W=5, and the entry struct
//   {instr, alusrc, regwrite}.
//  Sub-module esm_oldest_select: takes a bs-wide eligible vector and the bs x bs age matrix;
//   returns a one-hot grant, the granted slot index and an any flag. Purely combinational.
// TESTING
//  1 Independent: A=add x1,x2,x3 and B=add x4,x5,x6 offered back-to-back, out_ready=1
//    -> A issues after edge 2, B after edge 3, in order.
//  2 RAW and reorder: A writes x5 and issues; B reads x5; C=add x7,x8,x9
//    -> C issues before B; B issues one edge after wb_valid=1, wb_rd=5.
//  3 Full: out_ready=0 and 17 offers with bs=16 -> in_ready=0 after 16 enqueues plus 1 held in the
//    issue register; in_ready returns the cycle after out_ready=1.
//  4 Backpressure: out_ready=0 for 5 cycles while out_valid=1
//    -> Instr_out and out_slot are unchanged for all 5 cycles.
//  5 Collision: same edge has wb_valid for x3 and issue of a writer of x3
//    -> x3 stays busy; a later reader of x3 waits for the next wb_rd=3.
//  6 Reset mid-run: 6 entries buffered, rst=0 for 1 cycle
//    -> out_valid=0 immediately, in_ready=1 after release, and no stale entry ever issues.

Source files
------------

// File: rtl/esm_issue_scheduler_pkg.sv
// Shared field layout, buffer entry type and decode helpers for the ESM issue scheduler.
package esm_pkg;

  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned RS1_LSB   = 15;
  localparam int unsigned RS2_LSB   = 20;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned INSTR_W   = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               alusrc;
    logic               regwrite;
  } entry_t;

  function automatic reg_idx_t f_rd(entry_t e);
    return e.instr[RD_LSB +: REG_IDX_W];
  endfunction

  function automatic reg_idx_t f_rs1(entry_t e);
    return e.instr[RS1_LSB +: REG_IDX_W];
  endfunction

  function automatic reg_idx_t f_rs2(entry_t e);
    return e.instr[RS2_LSB +: REG_IDX_W];
  endfunction

  // x0 never reads or writes anything that matters for ordering
  function automatic logic reads_reg(entry_t e, reg_idx_t r);
    return (r != '0) && ((f_rs1(e) == r) || (!e.alusrc && (f_rs2(e) == r)));
  endfunction

  function automatic logic writes_reg(entry_t e, reg_idx_t r);
    return (r != '0) && e.regwrite && (f_rd(e) == r);
  endfunction

  // Hazard that an older entry o imposes on a younger entry y (RAW, WAW, WAR)
  function automatic logic order_hazard(entry_t o, entry_t y);
    return writes_reg(o, f_rs1(y))
        || (!y.alusrc && writes_reg(o, f_rs2(y)))
        || (y.regwrite && writes_reg(o, f_rd(y)))
        || (y.regwrite && reads_reg(o, f_rd(y)));
  endfunction

endpackage

// File: rtl/esm_issue_scheduler_if.sv
// Instruction-in, issue-out and writeback bundle of the ESM issue scheduler.
interface esm_issue_scheduler_if
  import esm_pkg::*;
#(
  parameter int unsigned Instr_word_size = 32,
  parameter int unsigned bs              = 16
);
  localparam int unsigned bs_bits = $clog2(bs);

  logic                       in_valid;
  logic                       in_ready;
  logic [Instr_word_size-1:0] Instr_in;
  logic                       ALUSrc;
  logic                       RegWrite;
  logic                       out_valid;
  logic                       out_ready;
  logic [Instr_word_size-1:0] Instr_out;
  logic [bs_bits-1:0]         out_slot;
  logic                       wb_valid;
  logic [REG_IDX_W-1:0]       wb_rd;

  modport slave (
    input  in_valid, Instr_in, ALUSrc, RegWrite, out_ready, wb_valid, wb_rd,
    output in_ready, out_valid, Instr_out, out_slot
  );

  modport master (
    output in_valid, Instr_in, ALUSrc, RegWrite, out_ready, wb_valid, wb_rd,
    input  in_ready, out_valid, Instr_out, out_slot
  );

endinterface

// File: rtl/esm_issue_scheduler_oldest_select.sv
// Picks the oldest eligible buffer entry using the pairwise age matrix (combinational).
module esm_oldest_select
  import esm_pkg::*;
#(
  parameter int unsigned bs = 16
) (
  input  logic [bs-1:0]          eligible,
  input  logic [bs-1:0][bs-1:0]  older,
  output logic [bs-1:0]          grant,
  output logic [$clog2(bs)-1:0]  slot,
  output logic                   any
);
  localparam int unsigned bs_bits = $clog2(bs);

  // older[j][e] = 1 means entry j was enqueued before entry e
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    grant   = '0;
    slot    = '0;
    for (int unsigned e = 0; e < bs; e++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < bs; j++) begin
        if (eligible[j] && older[j][e]) blocked = 1'b1;
      end
      grant[e] = eligible[e] && !blocked;
    end
    for (int unsigned e = 0; e < bs; e++) begin
      if (grant[e]) slot = slot | bs_bits'(e);
    end
  end

  assign any = |eligible;

endmodule

// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue scheduler: bs-entry buffer, register scoreboard, oldest-ready issue.
// Optional ESM_SCHED_STATS_EN adds stat_issued / stat_stalls counters.
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter int unsigned Instr_word_size = INSTR_W,
  parameter int unsigned regnum          = 32,
  parameter int unsigned bs              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  esm_issue_scheduler_if.slave  bus
`ifdef ESM_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stalls
`endif
);
  localparam int unsigned bs_bits = $clog2(bs);

  entry_t                     ent [bs];
  logic [bs-1:0]              valid_q, valid_nxt;
  logic [bs-1:0][bs-1:0]      older_q;
  logic [regnum-1:0]          sb_q, sb_nxt;
  logic                       out_valid_q;
  logic [Instr_word_size-1:0] instr_out_q;
  logic [bs_bits-1:0]         out_slot_q;

  logic                       full, can_load, do_enq, do_issue, grant_any;
  logic [bs_bits-1:0]         free_idx, grant_idx;
  logic [bs-1:0]              elig, grant;
  entry_t                     in_ent;

  assign full          = &valid_q;
  assign do_enq        = bus.in_valid && !full;
  assign can_load      = !out_valid_q || bus.out_ready;
  assign do_issue      = can_load && grant_any;
  assign in_ent        = '{instr: bus.Instr_in, alusrc: bus.ALUSrc, regwrite: bus.RegWrite};

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.Instr_out = instr_out_q;
  assign bus.out_slot  = out_slot_q;

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < bs; i++) begin
      if (!valid_q[i] && !found) begin
        free_idx = bs_bits'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    logic     ok;
    reg_idx_t rs1, rs2, rd;
    ok   = 1'b0;
    rs1  = '0;
    rs2  = '0;
    rd   = '0;
    elig = '0;
    for (int unsigned e = 0; e < bs; e++) begin
      rs1 = f_rs1(ent[e]);
      rs2 = f_rs2(ent[e]);
      rd  = f_rd(ent[e]);
      ok  = valid_q[e] && !sb_q[rs1] && (ent[e].alusrc || !sb_q[rs2])
         && (!ent[e].regwrite || !sb_q[rd]);
      for (int unsigned j = 0; j < bs; j++) begin
        if (valid_q[j] && older_q[j][e] && order_hazard(ent[j], ent[e])) ok = 1'b0;
      end
      elig[e] = ok;
    end
  end

  esm_oldest_select #(.bs(bs)) u_oldest_select (
    .eligible (elig),
    .older    (older_q),
    .grant    (grant),
    .slot     (grant_idx),
    .any      (grant_any)
  );

  // Writeback clear is applied first so a same-edge issue of a writer keeps the register busy
  always_comb begin
    valid_nxt = valid_q;
    if (do_issue) valid_nxt = valid_nxt & ~grant;
    if (do_enq)   valid_nxt[free_idx] = 1'b1;
    sb_nxt = sb_q;
    if (bus.wb_valid && (bus.wb_rd != '0)) sb_nxt[bus.wb_rd] = 1'b0;
    if (do_issue && ent[grant_idx].regwrite && (f_rd(ent[grant_idx]) != '0))
      sb_nxt[f_rd(ent[grant_idx])] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      older_q     <= '0;
      sb_q        <= '0;
      out_valid_q <= 1'b0;
      instr_out_q <= '0;
      out_slot_q  <= '0;
    end else begin
      if (can_load) begin
        out_valid_q <= grant_any;
        if (grant_any) begin
          instr_out_q <= ent[grant_idx].instr;
          out_slot_q  <= grant_idx;
        end
      end
      valid_q <= valid_nxt;
      sb_q    <= sb_nxt;
      // Rewriting both row and column of the new slot keeps stale bits of freed slots harmless
      if (do_enq) begin
        for (int unsigned j = 0; j < bs; j++) begin
          older_q[j][free_idx] <= valid_q[j];
          older_q[free_idx][j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) ent[free_idx] <= in_ent;
  end

`ifdef ESM_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      if (do_issue) stat_issued <= stat_issued + 32'd1;
      if ((|valid_q) && can_load && !grant_any) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Scoreboard bench for esm_issue_scheduler: age-ordered queue reference model plus monitor.
module tb_esm_issue_scheduler;
  localparam int unsigned BS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  esm_issue_scheduler_if #(.Instr_word_size(32), .bs(BS)) bus ();

`ifdef ESM_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stalls;
`endif

  esm_issue_scheduler #(.Instr_word_size(32), .regnum(32), .bs(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ESM_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stalls (stat_stalls)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    bit          alusrc;
    bit          regwrite;
    int unsigned slot;
  } ment_t;

  typedef struct {
    logic [31:0] instr;
    int unsigned slot;
  } exp_t;

  ment_t       mbuf[$];
  exp_t        exp_q[$];
  bit [31:0]   busy;
  bit          mov;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned m_rd(ment_t m);  return int'(m.instr[11:7]);  endfunction
  function automatic int unsigned m_rs1(ment_t m); return int'(m.instr[19:15]); endfunction
  function automatic int unsigned m_rs2(ment_t m); return int'(m.instr[24:20]); endfunction

  function automatic bit m_reads(ment_t m, int unsigned r);
    return (r != 0) && (m_rs1(m) == r || (!m.alusrc && m_rs2(m) == r));
  endfunction

  function automatic bit m_writes(ment_t m, int unsigned r);
    return (r != 0) && m.regwrite && m_rd(m) == r;
  endfunction

  function automatic bit m_ok(int k);
    ment_t e;
    ment_t o;
    e = mbuf[k];
    if (busy[m_rs1(e)]) return 0;
    if (!e.alusrc && busy[m_rs2(e)]) return 0;
    if (e.regwrite && busy[m_rd(e)]) return 0;
    for (int j = 0; j < k; j++) begin
      o = mbuf[j];
      if (m_writes(o, m_rs1(e))) return 0;
      if (!e.alusrc && m_writes(o, m_rs2(e))) return 0;
      if (e.regwrite && (m_writes(o, m_rd(e)) || m_reads(o, m_rd(e)))) return 0;
    end
    return 1;
  endfunction

  // One clock edge of the reference: issue oldest ready, apply writeback, then enqueue
  function automatic void model_edge();
    int          sel;
    int unsigned enq_slot;
    bit          do_enq;
    bit [BS-1:0] used;
    ment_t       ne;
    exp_t        x;
    sel      = -1;
    enq_slot = 0;
    used     = '0;
    do_enq   = bus.in_valid && (mbuf.size() < BS);
    if (do_enq) begin
      foreach (mbuf[k]) used[mbuf[k].slot] = 1'b1;
      for (int unsigned s = BS; s > 0; s--) if (!used[s-1]) enq_slot = s - 1;
    end
    if (!mov || bus.out_ready) begin
      for (int k = 0; k < mbuf.size(); k++) begin
        if (m_ok(k)) begin
          sel = k;
          break;
        end
      end
      mov = (sel >= 0);
      if (sel >= 0) begin
        x.instr = mbuf[sel].instr;
        x.slot  = mbuf[sel].slot;
        exp_q.push_back(x);
      end
    end
    if (bus.wb_valid && bus.wb_rd != 0) busy[bus.wb_rd] = 1'b0;
    if (sel >= 0) begin
      if (mbuf[sel].regwrite && m_rd(mbuf[sel]) != 0) busy[m_rd(mbuf[sel])] = 1'b1;
      mbuf.delete(sel);
    end
    if (do_enq) begin
      ne.instr    = bus.Instr_in;
      ne.alusrc   = bus.ALUSrc;
      ne.regwrite = bus.RegWrite;
      ne.slot     = enq_slot;
      mbuf.push_back(ne);
    end
  endfunction

  function automatic logic [31:0] mk(int unsigned rd, int unsigned rs1, int unsigned rs2);
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = 7'h33;
    w[11:7]  = 5'(rd);
    w[19:15] = 5'(rs1);
    w[24:20] = 5'(rs2);
    return w;
  endfunction

  task automatic step(bit iv, logic [31:0] ins, bit as, bit rw, bit ordy, bit wv, logic [4:0] wr);
    bus.in_valid  = iv;
    bus.Instr_in  = ins;
    bus.ALUSrc    = as;
    bus.RegWrite  = rw;
    bus.out_ready = ordy;
    bus.wb_valid  = wv;
    bus.wb_rd     = wr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int unsigned n, bit ordy);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0, '0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    rst = 1'b0;
    mbuf.delete();
    exp_q.delete();
    busy = '0;
    mov  = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_instr_out", bus.Instr_out, 32'd0);
    check("reset_out_slot", {28'd0, bus.out_slot}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: compares the issue register against the expected queue every cycle
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, mbuf.size() < BS});
      if (exp_q.size() != 0) begin
        if (bus.out_valid) begin
          check("instr_out", bus.Instr_out, exp_q[0].instr);
          check("out_slot", {28'd0, bus.out_slot}, exp_q[0].slot);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int unsigned busy_regs[$];
    bit          iv, as, rw, ordy, wv;
    logic [4:0]  wr;
    bus.in_valid  = 1'b0;
    bus.Instr_in  = '0;
    bus.ALUSrc    = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    busy = '0;
    mov  = 1'b0;
    #1;
    check("por_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Independent pair back to back
    step(1, mk(1, 2, 3), 0, 1, 1, 0, 0);
    step(1, mk(4, 5, 6), 0, 1, 1, 0, 0);
    idle(4, 1);
    do_reset();

    // RAW on x5 lets a later independent instruction overtake
    step(1, mk(5, 1, 2), 0, 1, 1, 0, 0);
    step(1, mk(10, 5, 6), 0, 1, 1, 0, 0);
    step(1, mk(7, 8, 9), 0, 1, 1, 0, 0);
    idle(4, 1);
    step(0, '0, 0, 0, 1, 1, 5'd5);
    idle(3, 1);
    do_reset();

    // Full buffer under backpressure, then drain
    for (int unsigned i = 0; i < 20; i++) step(1, mk(i + 1, 0, 0), 0, 1, 0, 0, 0);
    idle(5, 0);
    idle(24, 1);
    do_reset();

    // Writeback of x3 on the same edge a writer of x3 issues
    step(1, mk(3, 1, 2), 0, 1, 1, 0, 0);
    step(1, mk(4, 3, 0), 1, 1, 1, 1, 5'd3);
    idle(4, 1);
    step(0, '0, 0, 0, 1, 1, 5'd3);
    idle(3, 1);
    do_reset();

    // Reset with entries buffered: nothing stale may issue afterwards
    for (int unsigned i = 0; i < 7; i++) step(1, mk(i + 1, 0, 0), 0, 1, 0, 0, 0);
    do_reset();
    idle(10, 1);

    // Randomised traffic over a small register pool to provoke hazards
    for (int unsigned c = 0; c < 3000; c++) begin
      iv   = $urandom_range(0, 99) < 60;
      as   = $urandom_range(0, 99) < 30;
      rw   = $urandom_range(0, 99) < 80;
      ordy = $urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 85 : 40);
      wv   = 1'b0;
      wr   = '0;
      if ($urandom_range(0, 99) < 45) begin
        wv = 1'b1;
        wr = 5'($urandom_range(0, 7));
        busy_regs.delete();
        for (int unsigned r = 1; r < 8; r++) if (busy[r]) busy_regs.push_back(r);
        if (busy_regs.size() != 0 && $urandom_range(0, 3) != 0)
          wr = 5'(busy_regs[$urandom_range(0, busy_regs.size() - 1)]);
      end
      step(iv, mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
           as, rw, ordy, wv, wr);
      if (c == 1700) do_reset();
    end
    idle(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
